dma_hold_arbiter: RTL and testbench

- Shares the CPU-side system bus (RAM/ROM/peripheral path) between the gw8088 and up to NUM_REQ bus masters (DMA, UART buffer engine).
- Obtains the bus from the CPU with the HOLD/HLDA handshake and grants it to one requester at a time, round-robin.
- Bounds each grant so the CPU is guaranteed forward progress.
- Sits beside system_bus; its bus_sel output drives the address/data/strobe mux in front of the bus decoder.

---
 rtl/dma_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/dma_hold_arbiter.sv | 153 +++++++++++++++
 tb/tb_dma_hold_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and sizing helpers for the DMA/CPU bus hold arbiter and its
// round-robin picker.
package dma_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE     = 2'd0;
    localparam arb_state_t ST_HOLD_REQ = 2'd1;
    localparam arb_state_t ST_GRANT    = 2'd2;
    localparam arb_state_t ST_RELEASE  = 2'd3;

    localparam int BUS_SEL_CPU = 0;

    // bus_sel encodes CPU plus one code per master
    function automatic int bus_sel_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // counter wide enough to hold the value n itself
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest requester strictly above the last
// winner, wrapping to the lowest requester overall.
module rr_pick
    import dma_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]          req_i,
    input  logic [idx_w(N)-1:0]   last_i,
    output logic [N-1:0]          gnt_o,
    output logic [idx_w(N)-1:0]   idx_o,
    output logic                  valid_o
);

    localparam int IW = idx_w(N);

    logic [N-1:0] above;
    logic [N-1:0] masked;
    logic [N-1:0] cand;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign above[gi] = (last_i < IW'(gi));
        end
    endgenerate

    assign masked  = req_i & above;
    assign cand    = (|masked) ? masked : req_i;
    assign gnt_o   = cand & (~cand + N'(1));
    assign valid_o = |req_i;

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_o[i]) begin
                idx_o = idx_o | IW'(i);
            end
        end
    end

endmodule

// File: rtl/dma_hold_arbiter.sv
// Takes the system bus from the CPU via HOLD/HLDA and lends it round-robin to
// one master at a time, with a bounded grant and a guaranteed CPU window after.
module dma_hold_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_GRANT = 64,
    parameter int CPU_GAP   = 4,
    parameter int HLDA_TO   = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic                            cpu_hold_o,
    input  logic                            cpu_hlda_i,
    output logic [bus_sel_w(NUM_REQ)-1:0]   bus_sel_o,
    output logic                            busy_o,
    output logic                            hold_err_o,
    input  logic                            err_clr_i
);

    localparam int SW     = bus_sel_w(NUM_REQ);
    localparam int IW     = idx_w(NUM_REQ);
    localparam int GAP_W  = cnt_w(CPU_GAP);
    localparam int WAIT_W = cnt_w(HLDA_TO);
    localparam int GCNT_W = cnt_w(MAX_GRANT);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                hold_q, hold_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [IW-1:0]       last_q, last_d;
    logic [IW-1:0]       win_q, win_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
    logic                err_set;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [IW-1:0]       pick_idx;
    logic                pick_vld;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .gnt_o   (pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        last_d  = last_q;
        win_d   = win_q;
        gap_d   = gap_q;
        wait_d  = wait_q;
        gcnt_d  = gcnt_q;
        err_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gap_q != GAP_W'(CPU_GAP)) begin
                    gap_d = gap_q + GAP_W'(1);
                end else if (|req_i) begin
                    state_d = ST_HOLD_REQ;
                    hold_d  = 1'b1;
                    wait_d  = '0;
                end
            end
            ST_HOLD_REQ: begin
                wait_d = wait_q + WAIT_W'(1);
                // requests are judged on the same cycle HLDA is seen
                if (cpu_hlda_i && pick_vld) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_oh;
                    sel_d   = SW'(pick_idx) + SW'(1);
                    win_d   = pick_idx;
                    gcnt_d  = '0;
                end else if (cpu_hlda_i) begin
                    state_d = ST_RELEASE;
                    hold_d  = 1'b0;
                end else if (wait_q == WAIT_W'(HLDA_TO - 1)) begin
                    state_d = ST_RELEASE;
                    hold_d  = 1'b0;
                    err_set = 1'b1;
                end
            end
            ST_GRANT: begin
                gcnt_d = gcnt_q + GCNT_W'(1);
                if (!(|(req_i & gnt_q)) || gcnt_q == GCNT_W'(MAX_GRANT - 1)) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                    sel_d   = SW'(BUS_SEL_CPU);
                    hold_d  = 1'b0;
                    last_d  = win_q;
                end
            end
            default: begin
                // CPU window starts only once the CPU has taken the bus back
                if (!cpu_hlda_i) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        err_d  = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            hold_q  <= 1'b0;
            sel_q   <= SW'(BUS_SEL_CPU);
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= IW'(NUM_REQ - 1);
            win_q   <= '0;
            gap_q   <= GAP_W'(CPU_GAP);
            wait_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            last_q  <= last_d;
            win_q   <= win_d;
            gap_q   <= gap_d;
            wait_q  <= wait_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign cpu_hold_o = hold_q;
    assign bus_sel_o  = sel_q;
    assign busy_o     = busy_q;
    assign hold_err_o = err_q;

endmodule

// File: tb/tb_dma_hold_arbiter.sv
// Randomized and directed bench for dma_hold_arbiter against a bus-ownership
// reference model and a behavioural CPU HOLD/HLDA responder.
module tb_dma_hold_arbiter;

    localparam int N    = 2;
    localparam int MAXG = 64;
    localparam int GAP  = 4;
    localparam int TO   = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_i;
    logic [1:0] gnt_o;
    logic       cpu_hold_o;
    logic       cpu_hlda_i;
    logic [1:0] bus_sel_o;
    logic       busy_o;
    logic       hold_err_o;
    logic       err_clr_i;

    always #5 clk = ~clk;

    dma_hold_arbiter #(
        .NUM_REQ   (N),
        .MAX_GRANT (MAXG),
        .CPU_GAP   (GAP),
        .HLDA_TO   (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .cpu_hold_o (cpu_hold_o),
        .cpu_hlda_i (cpu_hlda_i),
        .bus_sel_o  (bus_sel_o),
        .busy_o     (busy_o),
        .hold_err_o (hold_err_o),
        .err_clr_i  (err_clr_i)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // CPU responder
    int lat = 2, rel_lat = 1, hi_cnt = 0, lo_cnt = 0;
    bit tie_low = 0, rand_lat = 0;

    // bus ownership model
    logic [1:0] m_gnt, m_sel;
    bit m_hold, m_busy, m_err;
    int m_w, m_len, m_wait, m_idle, last_w;
    int winners[$];
    int glens[$];
    int low_run = 0, hold_run = 0;
    bit had_grant = 0;

    function automatic int rr(input logic [1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_gnt = 0; m_sel = 0; m_hold = 0; m_busy = 0; m_err = 0;
        m_w = 0; m_len = 0; m_wait = 0; m_idle = GAP; last_w = N - 1;
    endtask

    task automatic step();
        logic [1:0] s_req;
        bit s_hlda, s_clr, tmo;
        s_req  = req_i;
        s_hlda = cpu_hlda_i;
        s_clr  = err_clr_i;
        @(posedge clk);
        #1;
        cyc++;
        tmo = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_gnt != 0) begin
                m_len++;
                if (!s_req[m_w] || m_len == MAXG) begin
                    m_gnt = 0; m_sel = 0; m_hold = 0; last_w = m_w;
                    glens.push_back(m_len);
                    had_grant = 1;
                end
            end else if (m_hold) begin
                m_wait++;
                if (s_hlda && s_req != 0) begin
                    m_w = rr(s_req, last_w);
                    m_gnt = 2'(1 << m_w);
                    m_sel = 2'(m_w + 1);
                    m_len = 0;
                    winners.push_back(m_w);
                end else if (s_hlda) begin
                    m_hold = 0;
                end else if (m_wait == TO) begin
                    m_hold = 0; tmo = 1;
                end
            end else if (m_busy) begin
                if (!s_hlda) begin m_busy = 0; m_idle = 0; end
            end else begin
                if (s_req != 0 && m_idle >= GAP) begin
                    m_hold = 1; m_busy = 1; m_wait = 0;
                end else if (m_idle < 1000) begin
                    m_idle++;
                end
            end
            if (tmo) m_err = 1;
            else if (s_clr) m_err = 0;
        end

        chk("gnt", gnt_o, m_gnt);
        chk("cpu_hold", cpu_hold_o, m_hold);
        chk("bus_sel", bus_sel_o, m_sel);
        chk("busy", busy_o, m_busy);
        chk("hold_err", hold_err_o, m_err);
        chk("gnt_onehot0", $onehot0(gnt_o), 1);
        if (gnt_o != 0) chk("gnt_needs_hlda", cpu_hlda_i, 1);

        if (cpu_hold_o) begin
            if (low_run == 0 && hold_run == 0) low_run = 0;
            if (hold_run == 0 && had_grant) begin
                chk("cpu_window", low_run >= GAP, 1);
                had_grant = 0;
            end
            hold_run++;
            low_run = 0;
        end else begin
            if (hold_run != 0 && tie_low) chk("hold_to_len", hold_run, TO);
            hold_run = 0;
            low_run++;
        end

        if (cpu_hold_o) begin
            if (hi_cnt == 0 && rand_lat) begin
                lat = $urandom_range(1, 4);
                rel_lat = $urandom_range(1, 3);
            end
            hi_cnt++; lo_cnt = 0;
        end else begin
            lo_cnt++; hi_cnt = 0;
        end
        if (cpu_hlda_i) begin
            if (lo_cnt >= rel_lat) cpu_hlda_i = 0;
        end else if (!tie_low && hi_cnt >= lat) begin
            cpu_hlda_i = 1;
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int base, t;
        rst_n = 0; req_i = 0; cpu_hlda_i = 0; err_clr_i = 0;
        model_reset();
        settle(3);
        rst_n = 1;
        settle(3);

        // single request, HLDA 3 cycles after HOLD
        lat = 3;
        base = glens.size();
        req_i = 2'b01;
        settle(12);
        req_i = 2'b00;
        settle(12);
        chk("single_grants", glens.size(), base + 1);
        chk("single_winner", winners[winners.size() - 1], 0);

        // continuous round-robin with preemption
        lat = 2;
        base = glens.size();
        req_i = 2'b11;
        t = 0;
        while (glens.size() < base + 4 && t < 1000) begin step(); t++; end
        chk("rr_done", glens.size() >= base + 4, 1);
        for (int k = 0; k < 4 && base + k < glens.size(); k++) begin
            chk("rr_len", glens[base + k], MAXG);
            if (k > 0) chk("rr_alternate", winners[winners.size() - 4 + k] != winners[winners.size() - 5 + k], 1);
        end
        req_i = 2'b00;
        settle(10);

        // HLDA timeout, then clear; second timeout with clear held (set wins)
        tie_low = 1;
        req_i = 2'b10;
        t = 0;
        while (!m_err && t < 400) begin step(); t++; end
        req_i = 2'b00;
        chk("to_flag_wait", m_err, 1);
        settle(8);
        chk("to_sticky", hold_err_o, 1);
        err_clr_i = 1;
        step();
        err_clr_i = 0;
        settle(6);
        req_i = 2'b01;
        err_clr_i = 1;
        t = 0;
        while (!m_err && t < 400) begin step(); t++; end
        req_i = 2'b00;
        step();
        err_clr_i = 0;
        settle(8);
        tie_low = 0;

        // withdrawn request
        lat = 3;
        base = winners.size();
        req_i = 2'b01;
        step();
        req_i = 2'b00;
        settle(20);
        chk("withdraw_no_gnt", winners.size(), base);

        // reset mid-grant of master 1
        req_i = 2'b10;
        t = 0;
        while (m_gnt != 2'b10 && t < 100) begin step(); t++; end
        chk("rst_setup", m_gnt, 2'b10);
        settle(5);
        #2 rst_n = 0;
        #1;
        chk("rst_async_gnt", gnt_o, 0);
        chk("rst_async_hold", cpu_hold_o, 0);
        chk("rst_async_sel", bus_sel_o, 0);
        model_reset();
        had_grant = 0;
        settle(3);
        rst_n = 1;
        req_i = 2'b11;
        base = winners.size();
        t = 0;
        while (winners.size() == base && t < 100) begin step(); t++; end
        chk("rst_first_winner", (winners.size() > base) ? winners[base] : -1, 0);

        // randomized traffic
        rand_lat = 1;
        for (int i = 0; i < 2500; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) req_i[b] = ~req_i[b];
            end
            err_clr_i = ($urandom_range(0, 31) == 0);
            step();
        end
        err_clr_i = 0;
        req_i = 0;
        settle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
